// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan driver.
// Glyphs are active-low {g,f,e,d,c,b,a} for a common-anode display.
package seg7_pkg;

    localparam int NUM_DIGITS = 5;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: digit input bus, display pins and debug state of seg7_scan.
//
// Handshake: update is a one-cycle valid strobe with no ready. The
// scanner always accepts it; the five digits are sampled on the same
// clock edge where update is high. There is no back-pressure.
interface seg7_scan_if;
    import seg7_pkg::*;

    bcd_t                  tens_of_thousands;
    bcd_t                  thousands;
    bcd_t                  hundreds;
    bcd_t                  tens;
    bcd_t                  ones;
    logic                  update;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] an;
    logic                  frame_start;
    logic [2:0]            dbg_idx;
    logic                  dbg_pend;

    modport master (
        output tens_of_thousands, thousands, hundreds, tens, ones, update,
        input  seg, an, frame_start, dbg_idx, dbg_pend
    );

    modport slave (
        input  tens_of_thousands, thousands, hundreds, tens, ones, update,
        output seg, an, frame_start, dbg_idx, dbg_pend
    );

endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-low segment pattern.
// Non-BCD codes 10..15 show a dash so bad upstream data is visible.
module seg7_decode
    import seg7_pkg::*;
(
    input  bcd_t       i_bcd,
    output logic [6:0] o_seg
);

    // Glyph lookup; anything outside 0..9 falls to the dash.
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for a five-digit common-anode display.
// Digits are staged on update and copied to the shadow only at the frame
// boundary, so a frame never mixes old and new digits. Each digit slot is
// SCAN_DIV cycles long and starts with BLANK_CYC cycles of all anodes off.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (suppress leading zeros).
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    seg7_scan_if.slave bus
);

    localparam int                   CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]           IDX_LAST  = 3'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = '1;

    logic [2:0]            r_idx;
    logic [CNT_W-1:0]      r_cnt;
    bcd_t                  r_stage  [NUM_DIGITS];
    bcd_t                  r_shadow [NUM_DIGITS];
    logic                  r_pend;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame_start;

    bcd_t                  w_in [NUM_DIGITS];
    logic                  w_slot_end;
    logic                  w_frame_end;
    logic                  w_in_blank;
    logic                  w_lz_blank;
    bcd_t                  w_cur_digit;
    logic [6:0]            w_glyph;

    assign w_in[0] = bus.ones;
    assign w_in[1] = bus.tens;
    assign w_in[2] = bus.hundreds;
    assign w_in[3] = bus.thousands;
    assign w_in[4] = bus.tens_of_thousands;

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
    assign w_cur_digit = r_shadow[r_idx];

    // With no blank interval the comparison would be constant, so skip it.
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign w_in_blank = 1'b0;
        end else begin : g_blank
            localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
            assign w_in_blank = (r_cnt < BLANK_END);
        end
    endgenerate

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] w_nz_above;

    // Bit i is set when digit i or any more significant digit is non-zero.
    always_comb begin
        w_nz_above = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            for (int j = i; j < NUM_DIGITS; j++) begin
                if (r_shadow[j] != 4'd0) begin
                    w_nz_above[i] = 1'b1;
                end
            end
        end
    end

    // The ones digit always shows, so a value of zero reads "0".
    assign w_lz_blank = (r_idx != 3'd0) && !w_nz_above[r_idx];
`else
    assign w_lz_blank = 1'b0;
`endif

    seg7_decode u_decode (
        .i_bcd (w_cur_digit),
        .o_seg (w_glyph)
    );

    // Slot counter and digit index; index wraps after the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Staging/shadow handshake; an update on the boundary bypasses staging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_stage[i]  <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            if (bus.update) begin
                r_stage <= w_in;
            end
            if (w_frame_end) begin
                r_pend <= 1'b0;
                if (bus.update) begin
                    r_shadow <= w_in;
                end else if (r_pend) begin
                    r_shadow <= r_stage;
                end
            end else if (bus.update) begin
                r_pend <= 1'b1;
            end
        end
    end

    // Registered pin drive from this cycle's index, count and shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an          <= AN_OFF;
            r_seg         <= SEG_BLANK;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= (r_idx == 3'd0) && (r_cnt == '0);
            if (w_in_blank) begin
                r_an  <= AN_OFF;
                r_seg <= SEG_BLANK;
            end else begin
                r_an  <= ~(NUM_DIGITS'(1) << r_idx);
                r_seg <= w_lz_blank ? SEG_BLANK : w_glyph;
            end
        end
    end

    assign bus.seg         = r_seg;
    assign bus.an          = r_an;
    assign bus.frame_start = r_frame_start;
    assign bus.dbg_idx     = r_idx;
    assign bus.dbg_pend    = r_pend;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized and directed bench for seg7_scan.
// Two instances share stimulus: one with a blank interval, one without.
// Honours SEG7_LEADING_ZERO_BLANK_EN in its reference model.
module tb_seg7_scan;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 5 * SD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_if bus ();
    seg7_scan_if bus_nb ();

    seg7_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    seg7_scan #(.SCAN_DIV(SD), .BLANK_CYC(0)) dut_nb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nb)
    );

    typedef struct {
        int          cyc;
        logic [19:0] d;
    } upd_t;

    upd_t        upd_q[$];
    int          cyc;
    int          n_checks;
    int          n_errors;
    logic [6:0]  glyph [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                  7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h3F,
                                  7'h3F, 7'h3F, 7'h3F, 7'h3F};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Displayed digits while the state is cycle s: the last update taken
    // on or before the boundary that closed the previous frame.
    function automatic logic [19:0] shadow_at(input int s);
        int          f;
        logic [19:0] r;
        f = (s / FRAME) * FRAME;
        r = 20'd0;
        foreach (upd_q[i]) begin
            if (upd_q[i].cyc < f) r = upd_q[i].d;
        end
        return r;
    endfunction

    function automatic logic pend_at(input int s);
        int   f;
        logic p;
        f = (s / FRAME) * FRAME;
        p = 1'b0;
        foreach (upd_q[i]) begin
            if (upd_q[i].cyc >= f && upd_q[i].cyc < s) p = 1'b1;
        end
        return p;
    endfunction

    task automatic exp_view(input int s, input int bc, output logic [4:0] an, output logic [6:0] seg);
        logic [19:0] sh;
        int          slot;
        int          c;
        sh   = shadow_at(s);
        slot = (s / SD) % 5;
        c    = s % SD;
        an   = 5'h1F;
        seg  = 7'h7F;
        if (c >= bc) begin
            an  = ~(5'd1 << slot);
            seg = glyph[sh[slot*4 +: 4]];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (slot != 0 && (sh >> (4 * slot)) == 20'd0) seg = 7'h7F;
`endif
        end
    endtask

    task automatic check_outputs();
        logic [4:0] e_an;
        logic [6:0] e_seg;
        logic       e_fs;
        if (cyc == 0) begin
            e_an = 5'h1F; e_seg = 7'h7F; e_fs = 1'b0;
            chk("an_rst", bus.an, e_an);
            chk("seg_rst", bus.seg, e_seg);
            chk("fs_rst", bus.frame_start, e_fs);
        end else begin
            e_fs = ((cyc - 1) % FRAME) == 0;
            exp_view(cyc - 1, BC, e_an, e_seg);
            chk("an", bus.an, e_an);
            chk("seg", bus.seg, e_seg);
            chk("frame_start", bus.frame_start, e_fs);
            exp_view(cyc - 1, 0, e_an, e_seg);
            chk("an_nb", bus_nb.an, e_an);
            chk("seg_nb", bus_nb.seg, e_seg);
            chk("frame_start_nb", bus_nb.frame_start, e_fs);
        end
        chk("idx", bus.dbg_idx, (cyc / SD) % 5);
        chk("pend", bus.dbg_pend, pend_at(cyc));
    endtask

    task automatic drive(input logic upd, input logic [19:0] d);
        bus.update = upd;            bus_nb.update = upd;
        bus.tens_of_thousands = d[19:16]; bus_nb.tens_of_thousands = d[19:16];
        bus.thousands = d[15:12];    bus_nb.thousands = d[15:12];
        bus.hundreds  = d[11:8];     bus_nb.hundreds  = d[11:8];
        bus.tens      = d[7:4];      bus_nb.tens      = d[7:4];
        bus.ones      = d[3:0];      bus_nb.ones      = d[3:0];
    endtask

    // One clock: present inputs during state cyc, then check the result.
    task automatic tick(input logic upd, input logic [19:0] d);
        upd_t e;
        drive(upd, d);
        if (upd) begin
            e.cyc = cyc;
            e.d   = d;
            upd_q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
        bus.update    = 1'b0;
        bus_nb.update = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 20'($urandom));
    endtask

    task automatic idle_to(input int phase);
        while ((cyc % FRAME) != phase) tick(1'b0, 20'($urandom));
    endtask

    task automatic check_reset_held();
        chk("an_hold", bus.an, 5'h1F);
        chk("seg_hold", bus.seg, 7'h7F);
        chk("fs_hold", bus.frame_start, 1'b0);
        chk("an_nb_hold", bus_nb.an, 5'h1F);
        chk("pend_hold", bus.dbg_pend, 1'b0);
        chk("idx_hold", bus.dbg_idx, 3'd0);
    endtask

    initial begin
        logic [19:0] d;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        drive(1'b0, 20'd0);

        // Reset held
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_held();
        rst_n = 1'b1;
        check_outputs();

        // Scan order: digits 4..0 = 1,2,3,4,5
        tick(1'b1, 20'h12345);
        idle(2 * FRAME + 5);

        // Tear-free update and last-update-wins
        tick(1'b1, 20'h00000);
        idle_to(0);
        idle_to(20);
        tick(1'b1, 20'h99999);
        idle_to(30);
        tick(1'b1, 20'h77777);
        idle_to(0);
        idle(FRAME + 5);

        // Boundary collision, overriding an earlier pending update
        idle_to(30);
        tick(1'b1, 20'h11111);
        idle_to(FRAME - 1);
        tick(1'b1, 20'h24680);
        idle(FRAME + 5);

        // Invalid BCD and leading-zero patterns
        tick(1'b1, 20'h1C3A5);
        idle(2 * FRAME);
        tick(1'b1, 20'h0C000);
        idle(2 * FRAME);
        tick(1'b1, 20'h00107);
        idle(2 * FRAME);
        tick(1'b1, 20'h00000);
        idle(2 * FRAME);
        tick(1'b1, 20'h00C00);
        idle(2 * FRAME);

        // Random updates with random leading-zero masks
        for (int i = 0; i < 600; i++) begin
            d = 20'($urandom);
            if ($urandom_range(0, 1) == 0) d = d >> (4 * $urandom_range(0, 5));
            tick($urandom_range(0, 9) == 0, d);
        end

        // Asynchronous reset mid-slot with an update pending
        idle_to(25);
        tick(1'b1, 20'h98765);
        idle(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_held();
        @(negedge clk);
        rst_n = 1'b1;
        upd_q.delete();
        cyc = 0;
        check_outputs();
        idle(FRAME + 10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed driver for the counter's five-digit common-anode 7-segment display. Consumes the five BCD digits from the binary-to-BCD converter, holds them in tear-free staging/shadow registers, and scans one digit at a time with a programmable dwell and anti-ghosting blank interval. Sits directly downstream of the BCD conversion stage and drives the board's segment and anode pins.

## Interface
- `SCAN_DIV`, 50000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYC`, 500: cycles at the start of each slot with all anodes off; 0 ≤ `BLANK_CYC` < `SCAN_DIV`.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `tens_of_thousands`, `thousands`, `hundreds`, `tens`, `ones`  in  4 each  BCD digits (digit 4..0)
- `update`  in  1  single-cycle strobe: capture the five digits
- `seg`  out  7  `{g,f,e,d,c,b,a}`, active-low
- `an`  out  5  digit enables, active-low; `an[0]` = ones, `an[4]` = tens of thousands
- `frame_start`  out  1  one-cycle pulse at the start of each digit-0 slot

## Operation
- **State:**
  - `idx` (0..4), slot counter `cnt` (0..`SCAN_DIV`-1).
  - `stage[4:0]` (staging digits), `shadow[4:0]` (displayed digits), `pend` flag.
- **Update handshake:**
  - `update`=1: load `stage` from inputs, set `pend`. Last `update` before a frame boundary wins.
  - Frame boundary (`idx`=4 and `cnt`=`SCAN_DIV`-1) with `pend`=1: `shadow` ← `stage`, clear `pend`.
  - `update` on the boundary cycle: that cycle's inputs go directly into `shadow`, and `pend` stays 0.
  - Shadow never changes mid-frame.
- **Scan:**
  - `cnt` increments every cycle.
  - At `SCAN_DIV`-1, `cnt` → 0 and `idx` → `idx`+1, wrapping 4 → 0.
- **Phases within a slot:**
  - BLANK: `cnt` < `BLANK_CYC`, `an`=5'b11111, `seg`=7'h7F.
  - ON: otherwise, `an` has only bit `idx` low, and `seg` = decode(`shadow[idx]`).
- **Decode:**
  - 0–9: standard glyphs, e.g. 0→7'h40, 1→7'h79, 8→7'h00.
  - Values 10–15: dash, 7'h3F (g only).
- **`frame_start`:** asserted for the cycle where `idx`=0 and `cnt`=0.

## Timing
- Reset values: `idx`=0, `cnt`=0, `stage`=`shadow`=0, `pend`=0, `an`=5'b11111, `seg`=7'h7F, `frame_start`=0.
- Outputs are registered: outputs at cycle t+1 reflect (`idx`, `cnt`, `shadow`) at cycle t.
- First ON cycle after reset release appears at cycle `BLANK_CYC`+1. Digit 0 is driven while `cnt` runs `BLANK_CYC`..`SCAN_DIV`-1.
- Frame period is 5·`SCAN_DIV` cycles. Update-to-display latency is at most one frame plus 1 cycle.
- `BLANK_CYC`=0: no blank phase; anodes switch directly between adjacent digits.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The pending update is discarded.

## Configuration
- Macro `SEG7_LEADING_ZERO_BLANK_EN`.
- **Defined:** digit i (i ≥ 1) is blanked during its ON phase (`seg`=7'h7F, `an` still asserted) when `shadow[i]` and all higher shadow digits are 0.
  - Digit 0 is never blanked; value 0 shows a single "0".
  - A digit of 10–15 is non-zero, so it stops blanking.
- **Undefined:** all five digits are always shown, including leading zeros.

## Structure
- Package `seg7_pkg`:
  - Glyph constants (`SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_BLANK`).
  - Digit-count constant `NUM_DIGITS`=5.
  - Typedef for a 4-bit BCD digit.
- Sub-module `seg7_decode`: combinational, 4-bit BCD in → 7-bit active-low segments out, using the package constants.
- Top-level `seg7_scan` holds the counters, handshake registers and output registers.

## Test plan
All scenarios use `SCAN_DIV`=8 and `BLANK_CYC`=2 unless stated otherwise.

- **Reset:** hold `rst_n`=0 → `an`=5'b11111, `seg`=7'h7F, `frame_start`=0. Release → `frame_start` pulses at cycle 1; `an`=5'b11110 first appears at cycle 3.
- **Scan order:** load 1,2,3,4,5 (digit 4..0) and wait one frame → slots show 5,4,3,2,1 on `an[0]`..`an[4]`, each with 2 blank + 6 ON cycles. The period is 40 cycles.
- **Tear-free update:** with 0,0,0,0,0 showing, pulse `update` with 9,9,9,9,9 mid-digit-2 → digits 2–4 still show 0 for this frame. Next frame shows all 9s. A second `update` before the boundary with 7s → 7s win.
- **Boundary collision:** `update` exactly on the `idx`=4, `cnt`=7 cycle → the new digits show from the next frame and `pend`=0 afterward.
- **Invalid BCD:** digit value 4'hC → dash (7'h3F) in that slot.
- **Leading-zero blanking:**
  - With the macro defined, shadow 0,0,1,0,7 → digits 4,3 blanked; digits 2,1,0 show 1,0,7. Shadow all 0 → only the ones digit shows "0".
  - Without the macro, shadow 0,0,1,0,7 shows all five digits, leading zeros included.
